// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit 16-function ALU: function codes, flag bit
// positions and the buffered result-entry layout.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_NAND  = 4'h8;
    localparam logic [3:0] OP_NOR   = 4'h9;
    localparam logic [3:0] OP_XNOR  = 4'hA;
    localparam logic [3:0] OP_PASSA = 4'hB;
    localparam logic [3:0] OP_PASSB = 4'hC;
    localparam logic [3:0] OP_SHL   = 4'hD;
    localparam logic [3:0] OP_SHR   = 4'hE;
    localparam logic [3:0] OP_ZERO  = 4'hF;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] flags;
        logic [3:0] op;
    } res_entry_t;

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational Z/N/C/V generation for one ALU result nibble; V is only
// meaningful for the add and subtract function codes.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter logic [3:0] ADD_OP = OP_ADD,
    parameter logic [3:0] SUB_OP = OP_SUB
) (
    input  logic [3:0] data,
    input  logic       cout,
    input  logic [3:0] op,
    input  logic       a3,
    input  logic       b3,
    output logic [3:0] flags
);

    // Flag derivation; b3 arrives already inverted for subtract, so one V rule serves both.
    always_comb begin
        flags        = 4'b0000;
        flags[FLG_Z] = (data == 4'h0);
        flags[FLG_N] = data[3];
        flags[FLG_C] = cout;
        if ((op == ADD_OP) || (op == SUB_OP)) begin
            flags[FLG_V] = (a3 == b3) & (data[3] != a3);
        end else begin
            flags[FLG_V] = 1'b0;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result FIFO behind the ALU adder: stores result, flags and op,
// hands them out over valid/ready, and tracks sticky overflow and pop count.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int         DEPTH  = 2,
    parameter logic [3:0] ADD_OP = OP_ADD,
    parameter logic [3:0] SUB_OP = OP_SUB,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             in_cout,
    input  logic [3:0]       in_op,
    input  logic             in_a3,
    input  logic             in_b3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [3:0]       out_flags,
    output logic [3:0]       out_op,
    output logic             ovf_sticky,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] res_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNTR_W = $clog2(DEPTH) + 1;
    localparam logic [CNTR_W-1:0] DEPTH_C = CNTR_W'(DEPTH);

    logic [3:0]        flags_s;
    res_entry_t        new_entry_s;
    logic              push_s;
    logic              pop_s;
    logic [CNTR_W-1:0] count_r;
    logic [CNTR_W-1:0] count_nxt_s;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    res_entry_t        mem_r [DEPTH];
    res_entry_t        head_r;
    res_entry_t        head_nxt_s;
    logic              sticky_r;
    logic [CNT_W-1:0]  res_cnt_r;

    alu_flag_gen #(
        .ADD_OP (ADD_OP),
        .SUB_OP (SUB_OP)
    ) u_flag_gen (
        .data  (in_data),
        .cout  (in_cout),
        .op    (in_op),
        .a3    (in_a3),
        .b3    (in_b3),
        .flags (flags_s)
    );

    assign new_entry_s = '{data: in_data, flags: flags_s, op: in_op};
    assign in_ready    = (count_r < DEPTH_C);
    assign out_valid   = (count_r != {CNTR_W{1'b0}});
    assign push_s      = in_valid & in_ready;
    assign pop_s       = out_valid & out_ready;

    // Next occupancy, read pointer and head entry; head_r holds the last popped entry when drained.
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = head_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNTR_W'(1);
            2'b01:   count_nxt_s = count_r - CNTR_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (count_nxt_s == {CNTR_W{1'b0}}) begin
            head_nxt_s = head_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = new_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers, occupancy and registered head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNTR_W{1'b0}};
            head_r   <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= new_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
        end
    end

    // Sticky overflow (set wins over clear) and delivered-result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r  <= 1'b0;
            res_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s && flags_s[FLG_V]) begin
                sticky_r <= 1'b1;
            end else if (clr_sticky) begin
                sticky_r <= 1'b0;
            end
            if (pop_s) begin
                res_cnt_r <= res_cnt_r + CNT_W'(1);
            end
        end
    end

    assign out_data   = head_r.data;
    assign out_flags  = head_r.flags;
    assign out_op     = head_r.op;
    assign ovf_sticky = sticky_r;
    assign res_cnt    = res_cnt_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag vector table plus hand-written
// backpressure, sticky-priority, counter-wrap and async-reset sequences.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_cout;
    logic [3:0] in_op;
    logic       in_a3;
    logic       in_b3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [3:0] out_flags;
    logic [3:0] out_op;
    logic       ovf_sticky;
    logic       clr_sticky;
    logic [7:0] res_cnt;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_cnt;

    typedef struct {
        string      name;
        logic [3:0] data;
        logic       cout;
        logic [3:0] op;
        logic       a3;
        logic       b3;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs [8];

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_cout    (in_cout),
        .in_op      (in_op),
        .in_a3      (in_a3),
        .in_b3      (in_b3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .out_op     (out_op),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky),
        .res_cnt    (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic c,
                         input logic [3:0] op, input logic a, input logic b);
        in_valid = v;
        in_data  = d;
        in_cout  = c;
        in_op    = op;
        in_a3    = a;
        in_b3    = b;
    endtask

    initial begin
        //              name          data  cout op       a3    b3    {Z,N,C,V}
        vecs[0] = '{"add_basic",   4'h5, 1'b0, OP_ADD, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{"add_ovf",     4'h8, 1'b0, OP_ADD, 1'b0, 1'b0, 4'b0101};
        vecs[2] = '{"add_zero_c",  4'h0, 1'b1, OP_ADD, 1'b1, 1'b0, 4'b1010};
        vecs[3] = '{"not_no_v",    4'h8, 1'b0, OP_NOT, 1'b0, 1'b0, 4'b0100};
        vecs[4] = '{"and_neg_c",   4'hF, 1'b1, OP_AND, 1'b1, 1'b1, 4'b0110};
        vecs[5] = '{"sub_ovf",     4'h3, 1'b1, OP_SUB, 1'b1, 1'b1, 4'b0011};
        vecs[6] = '{"sub_no_ovf",  4'h8, 1'b0, OP_SUB, 1'b0, 1'b1, 4'b0100};
        vecs[7] = '{"or_zero",     4'h0, 1'b0, OP_OR,  1'b0, 1'b0, 4'b1000};

        rst_n      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        exp_cnt    = 8'd0;
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Reset state
        repeat (3) cyc();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_op", out_op, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_res_cnt", res_cnt, 0);
        rst_n = 1'b1;
        cyc();
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // Flag vector table: push, check head next cycle, pop with sticky clear
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].data, vecs[i].cout, vecs[i].op, vecs[i].a3, vecs[i].b3);
            cyc();
            check({vecs[i].name, "_valid"}, out_valid, 1);
            check({vecs[i].name, "_data"}, out_data, vecs[i].data);
            check({vecs[i].name, "_flags"}, out_flags, vecs[i].flags);
            check({vecs[i].name, "_op"}, out_op, vecs[i].op);
            check({vecs[i].name, "_sticky"}, ovf_sticky, vecs[i].flags[0]);
            in_valid   = 1'b0;
            clr_sticky = 1'b1;
            cyc();
            exp_cnt++;
            clr_sticky = 1'b0;
            check({vecs[i].name, "_drained"}, out_valid, 0);
            check({vecs[i].name, "_hold"}, out_data, vecs[i].data);
            check({vecs[i].name, "_sticky_clr"}, ovf_sticky, 0);
            check({vecs[i].name, "_cnt"}, res_cnt, exp_cnt);
        end

        // Backpressure: fill, hold a third, drain in order
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 1'b0, OP_OR, 1'b0, 1'b0);
        cyc();
        check("bp_ready_1", in_ready, 1);
        in_data = 4'h2;
        cyc();
        check("bp_ready_full", in_ready, 0);
        check("bp_head_1", out_data, 4'h1);
        in_data = 4'h3;
        repeat (2) cyc();
        check("bp_held_ready", in_ready, 0);
        check("bp_held_head", out_data, 4'h1);
        out_ready = 1'b1;
        cyc();
        exp_cnt++;
        check("bp_pop1_head", out_data, 4'h2);
        check("bp_pop1_ready", in_ready, 1);
        cyc();
        exp_cnt++;
        check("bp_pushpop_head", out_data, 4'h3);
        check("bp_pushpop_valid", out_valid, 1);
        check("bp_pushpop_ready", in_ready, 1);
        in_valid = 1'b0;
        cyc();
        exp_cnt++;
        check("bp_empty", out_valid, 0);
        check("bp_cnt", res_cnt, exp_cnt);

        // Set beats clear on the same cycle
        clr_sticky = 1'b1;
        drive(1'b1, 4'h8, 1'b0, OP_ADD, 1'b0, 1'b0);
        cyc();
        check("sticky_set_wins", ovf_sticky, 1);
        in_valid = 1'b0;
        cyc();
        exp_cnt++;
        clr_sticky = 1'b0;
        check("sticky_cleared", ovf_sticky, 0);

        // Streaming run that wraps the delivered-result counter back to zero
        begin
            int n;
            logic [3:0] d;
            n = 256 - int'(exp_cnt);
            for (int i = 0; i < n; i++) begin
                d = i[3:0];
                drive(1'b1, d, 1'b0, OP_OR, 1'b0, 1'b0);
                cyc();
                check("stream_head", out_data, d);
            end
            in_valid = 1'b0;
            cyc();
            exp_cnt = exp_cnt + n[7:0];
            check("wrap_cnt_model", res_cnt, exp_cnt);
            check("wrap_cnt_zero", res_cnt, 0);
            check("wrap_empty", out_valid, 0);
        end

        // Async reset with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, 4'hA, 1'b0, OP_OR, 1'b0, 1'b0);
        cyc();
        in_data = 4'hB;
        cyc();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 0);
        check("pre_rst_head", out_data, 4'hA);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_cnt", res_cnt, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) cyc();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_cnt", res_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
